// File: rtl/merge_pkg.sv
// Shared types and defaults for the merge datapath stages.
package merge_pkg;

  localparam int unsigned MERGE_WORD_W = 8;

  typedef enum logic [0:0] {
    FILL,
    HOLD
  } merge_packer_state_t;

endpackage

// File: rtl/merge_packer_asm.sv
// Assembly shift register for merge_packer: places serial bits LSB first and
// tracks how many are held. The parent decides when bits are written or drained.
module merge_packer_asm
  import merge_pkg::*;
#(
  parameter int unsigned WIDTH = MERGE_WORD_W,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             wr_en,
  input  logic             drain,
  input  logic             wrap,
  output logic [WIDTH-1:0] asm_word,
  output logic [CW-1:0]    fill_cnt,
  output logic             full,
  output logic             complete_now
);

  logic [WIDTH-1:0] asm_q, asm_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    widx;

  // A drain empties the register, so a bit arriving with it lands at index 0.
  assign widx = drain ? '0 : cnt_q;

  always_comb begin
    asm_d = asm_q;
    cnt_d = cnt_q;
    if (drain) cnt_d = '0;
    if (wr_en) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (widx == CW'(i)) asm_d[i] = bit_in;
      end
      cnt_d = widx + CW'(1);
    end
    if (wrap) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q <= '0;
      cnt_q <= '0;
    end else begin
      asm_q <= asm_d;
      cnt_q <= cnt_d;
    end
  end

  assign asm_word     = asm_q;
  assign fill_cnt     = cnt_q;
  assign full         = (cnt_q == CW'(WIDTH));
  assign complete_now = wr_en && !drain && (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/merge_packer.sv
// Packs the serial merge stream into WIDTH-bit words on a valid/ready port,
// dropping and flagging bits once both stores are full. MERGE_PACKER_PARITY_EN adds word_parity.
module merge_packer
  import merge_pkg::*;
#(
  parameter int unsigned WIDTH = MERGE_WORD_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         bit_in,
  input  logic                         bit_valid,
  output logic [WIDTH-1:0]             word_out,
  output logic                         word_valid,
  input  logic                         word_ready,
`ifdef MERGE_PACKER_PARITY_EN
  output logic                         word_parity,
`endif
  output logic                         overflow,
  output logic [$clog2(WIDTH+1)-1:0]   fill_cnt
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  merge_packer_state_t state_q, state_d;

  logic             slot_free;
  logic             wr_en, drain, wrap, load;
  logic             full, complete_now;
  logic [WIDTH-1:0] asm_word, load_word;
  logic [WIDTH-1:0] word_d;
  logic             word_valid_d, overflow_d;

  assign slot_free = !word_valid || word_ready;

  // In HOLD a bit is only taken when the held word can move out on the same edge.
  assign wr_en = bit_valid && ((state_q == FILL) || slot_free);
  assign drain = (state_q == HOLD) && slot_free;
  assign wrap  = complete_now && slot_free;
  assign load  = wrap || drain;

  // A full register already holds the word; otherwise the incoming bit completes it.
  assign load_word = full ? asm_word : {bit_in, asm_word[WIDTH-2:0]};

  merge_packer_asm #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .bit_in       (bit_in),
    .wr_en        (wr_en),
    .drain        (drain),
    .wrap         (wrap),
    .asm_word     (asm_word),
    .fill_cnt     (fill_cnt),
    .full         (full),
    .complete_now (complete_now)
  );

  always_comb begin
    state_d    = state_q;
    overflow_d = overflow;
    unique case (state_q)
      FILL: if (complete_now && !slot_free) state_d = HOLD;
      HOLD: begin
        if (slot_free) state_d = FILL;
        else if (bit_valid) overflow_d = 1'b1;
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    word_d       = word_out;
    word_valid_d = word_valid;
    if (load) begin
      word_d       = load_word;
      word_valid_d = 1'b1;
    end else if (word_ready) begin
      word_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      word_out   <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_out   <= word_d;
      word_valid <= word_valid_d;
      overflow   <= overflow_d;
    end
  end

`ifdef MERGE_PACKER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_parity <= 1'b0;
    end else if (load) begin
      word_parity <= ^load_word;
    end
  end
`endif

endmodule

// File: tb/tb_merge_packer.sv
// Directed self-checking bench for merge_packer (WIDTH = 8).
module tb_merge_packer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic [7:0] word_out;
  logic       word_valid;
  logic       word_ready = 1'b0;
  logic       overflow;
  logic [3:0] fill_cnt;
`ifdef MERGE_PACKER_PARITY_EN
  logic       word_parity;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  merge_packer #(
    .WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
`ifdef MERGE_PACKER_PARITY_EN
    .word_parity(word_parity),
`endif
    .overflow   (overflow),
    .fill_cnt   (fill_cnt)
  );

  // Checks happen at a falling edge before new inputs are applied.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic b, input logic v);
    tick();
    bit_in    = b;
    bit_valid = v;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) drive(w[i], 1'b1);
  endtask

  task automatic do_reset();
    tick();
    rst_n      = 1'b0;
    bit_valid  = 1'b0;
    word_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (word_out !== 8'h00) begin n_err++; $display("FAIL reset_word_out: got %h want 00", word_out); end
    n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL reset_word_valid: got %b want 0", word_valid); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_vec++; if (fill_cnt !== 4'd0) begin n_err++; $display("FAIL reset_fill_cnt: got %0d want 0", fill_cnt); end
`ifdef MERGE_PACKER_PARITY_EN
    n_vec++; if (word_parity !== 1'b0) begin n_err++; $display("FAIL reset_parity: got %b want 0", word_parity); end
`endif
  endtask

  task automatic test_basic_word();
    do_reset();
    word_ready = 1'b1;
    send_word(8'h4D);
    tick();
    bit_valid = 1'b0;
    n_vec++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", word_valid); end
    n_vec++; if (word_out !== 8'h4D) begin n_err++; $display("FAIL basic_word: got %h want 4d", word_out); end
    n_vec++; if (fill_cnt !== 4'd0) begin n_err++; $display("FAIL basic_fill: got %0d want 0", fill_cnt); end
`ifdef MERGE_PACKER_PARITY_EN
    n_vec++; if (word_parity !== 1'b0) begin n_err++; $display("FAIL parity_4d: got %b want 0", word_parity); end
`endif
    tick();
    n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL basic_drop_valid: got %b want 0", word_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    word_ready = 1'b0;
    send_word(8'h4D);
    send_word(8'hFF);
    tick();
    n_vec++; if (fill_cnt !== 4'd8) begin n_err++; $display("FAIL ovf_hold_fill: got %0d want 8", fill_cnt); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", overflow); end
    bit_in    = 1'b0;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", overflow); end
    n_vec++; if (word_out !== 8'h4D) begin n_err++; $display("FAIL ovf_word_stable: got %h want 4d", word_out); end
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    n_vec++; if (word_out !== 8'hFF) begin n_err++; $display("FAIL ovf_next_word: got %h want ff", word_out); end
    n_vec++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL ovf_gapless_valid: got %b want 1", word_valid); end
    n_vec++; if (fill_cnt !== 4'd0) begin n_err++; $display("FAIL ovf_drain_fill: got %0d want 0", fill_cnt); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    word_ready = 1'b1;
    send_word(8'h0F);
    for (int i = 0; i < 8; i++) begin
      drive(i >= 4, 1'b1);
      if (i == 0) begin
        n_vec++; if (word_valid !== 1'b1 || word_out !== 8'h0F) begin
          n_err++; $display("FAIL b2b_first: got v=%b %h want v=1 0f", word_valid, word_out);
        end
      end
    end
    tick();
    bit_valid = 1'b0;
    n_vec++; if (word_valid !== 1'b1 || word_out !== 8'hF0) begin
      n_err++; $display("FAIL b2b_second: got v=%b %h want v=1 f0", word_valid, word_out);
    end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    word_ready = 1'b0;
    send_word(8'h4D);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
    tick();
    bit_valid = 1'b0;
    n_vec++; if (fill_cnt !== 4'd3) begin n_err++; $display("FAIL mid_pre_fill: got %0d want 3", fill_cnt); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (fill_cnt !== 4'd0) begin n_err++; $display("FAIL mid_fill: got %0d want 0", fill_cnt); end
    n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", word_valid); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mid_overflow: got %b want 0", overflow); end
    n_vec++; if (word_out !== 8'h00) begin n_err++; $display("FAIL mid_word: got %h want 00", word_out); end
    tick();
    rst_n      = 1'b1;
    word_ready = 1'b1;
    send_word(8'h07);
    tick();
    bit_valid = 1'b0;
    n_vec++; if (word_valid !== 1'b1 || word_out !== 8'h07) begin
      n_err++; $display("FAIL mid_next_word: got v=%b %h want v=1 07", word_valid, word_out);
    end
`ifdef MERGE_PACKER_PARITY_EN
    n_vec++; if (word_parity !== 1'b1) begin n_err++; $display("FAIL parity_07: got %b want 1", word_parity); end
`endif
  endtask

  task automatic test_gapped();
    logic [7:0] pat;
    pat = 8'hA5;
    do_reset();
    word_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(pat[i], 1'b1);
      if (i < 7) drive(~pat[i], 1'b0);
      if (i == 3) begin
        n_vec++; if (fill_cnt !== 4'd4) begin n_err++; $display("FAIL gap_fill: got %0d want 4", fill_cnt); end
      end
    end
    n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL gap_early: got %b want 0", word_valid); end
    tick();
    bit_valid = 1'b0;
    n_vec++; if (word_valid !== 1'b1 || word_out !== 8'hA5) begin
      n_err++; $display("FAIL gap_word: got v=%b %h want v=1 a5", word_valid, word_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_overflow();
    test_back_to_back();
    test_reset_mid_word();
    test_gapped();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/merge_packer.md
# merge_packer

Downstream stage of the tainted merge datapath. Collects the registered 1-bit `out` stream of the merge stage into WIDTH-bit words, LSB first, and presents them on a valid/ready output port. The input cannot be back-pressured, so bits arriving while both internal word stores are full are dropped and flagged. Taint flows from `bit_in` to `word_out`: `bit_in` is a taint source and `word_out` is a taint sink.

## Interface
- `WIDTH`, default 8: bits per output word; legal range is WIDTH ≥ 2.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `bit_in`  input  1  serial data bit from the merge stage.
- `bit_valid`  input  1  `bit_in` is meaningful this cycle.
- `word_out`  output  WIDTH  completed word; bit 0 is the first bit received.
- `word_valid`  output  1  `word_out` holds an unconsumed word.
- `word_ready`  input  1  consumer accepts the word this cycle.
- `overflow`  output  1  sticky flag; at least one valid bit has been dropped.
- `fill_cnt`  output  $clog2(WIDTH+1)  number of bits held in the assembly register.

## Operation
- Storage:
  - assembly shift register `asm`, with bit count `fill_cnt`;
  - output register `word_out`, with flag `word_valid`.
- Output handshake:
  - `slot_free = !word_valid || word_ready`.
  - A word is consumed on an edge where `word_valid && word_ready`.
- State machine, two states:
  - **FILL**:
    - Each edge with `bit_valid` writes `bit_in` into `asm[fill_cnt]` and increments `fill_cnt`.
    - On the edge that accepts bit WIDTH-1:
      - if `slot_free`: the completed word, including this bit, loads `word_out`; `word_valid` is set to 1; `fill_cnt` goes to 0; state stays FILL.
      - otherwise: the word stays in `asm`; `fill_cnt` goes to WIDTH; state goes to HOLD.
  - **HOLD**:
    - If `slot_free`: `asm` transfers to `word_out`, `word_valid` is set to 1, and state goes to FILL. If `bit_valid` is also high on that edge, the bit is accepted as bit 0 of the next word (`fill_cnt` goes to 1); otherwise `fill_cnt` goes to 0.
    - If not `slot_free` and `bit_valid` is high: the bit is dropped and `overflow` is set to 1.
- `word_valid` falls on a consuming edge unless a new word loads on that same edge. Simultaneous consume and load gives a gapless back-to-back transfer.
- `overflow` clears only on reset.
- `word_out` is stable whenever `word_valid` is high and no consume has occurred.
- `bit_in` is ignored whenever `bit_valid` is 0.
- Reset values: `word_out`=0, `word_valid`=0, `overflow`=0, `fill_cnt`=0, state FILL, `asm`=0.

## Timing
- Latency: `word_valid` rises in the cycle after the edge that accepts bit WIDTH-1, provided the slot is free.
- Sustained throughput is one bit per cycle with no loss while the consumer drains at least one word per WIDTH cycles.
- Capacity: up to 2·WIDTH bits are buffered before the next valid bit is dropped.
- Reset asserted mid-word or mid-HOLD clears all state immediately, without waiting for a clock edge. The first valid bit after release becomes bit 0.
- Outputs are registered; there is no combinational path from `bit_in` or `word_ready` to any output.

## Configuration
- Macro: `MERGE_PACKER_PARITY_EN`.
  - **Defined**: adds output `word_parity` (1 bit) = XOR of all bits of `word_out`. It is registered, loads together with `word_out`, and resets to 0.
  - **Undefined**: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `merge_pkg`:
  - `MERGE_WORD_W` = 8, the default for WIDTH;
  - state enum `merge_packer_state_t` {FILL, HOLD}.
- Sub-module `merge_packer_asm`: the assembly shift register plus `fill_cnt`. It exposes `full` and `complete_now` to the parent, which owns the FSM, output register and flags.
- The top level contains everything else; no further hierarchy.

## Test plan
- **Basic word**: WIDTH=8, `word_ready`=1, continuous valid bits 1,0,1,1,0,0,1,0 → `word_out`=8'h4D and `word_valid`=1 in the cycle after the 8th bit; `word_valid`=0 the following cycle.
- **Overflow**: `word_ready`=0; feed 8'h4D, then 8'hFF, then one extra valid bit → `word_out` stays 8'h4D; HOLD is reached with `fill_cnt`=8; `overflow`=1 after the 17th bit. Raise `word_ready` for one cycle → `word_out`=8'hFF next.
- **Back-to-back**: `word_ready` held at 1; 16 consecutive bits forming 8'h0F then 8'hF0 → `word_valid` stays high for two consecutive words with no gap cycle; `overflow` stays 0.
- **Reset mid-word**: after 3 valid bits, pulse `rst_n` low between edges → `fill_cnt`=0, `word_valid`=0, `overflow`=0 immediately. The next 8 bits 1,1,1,0,0,0,0,0 give 8'h07.
- **Gapped input**: `bit_valid` toggling 1/0 with bits of 8'hA5 → `word_out`=8'hA5 after 15 cycles; bits presented while `bit_valid`=0 are ignored.
- **Parity** (with `MERGE_PACKER_PARITY_EN`): 8'h4D → `word_parity`=0; 8'h07 → `word_parity`=1; reset → 0.
